// File: rtl/pmem_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_CH cache-line clients onto a single physical-memory
// port, with registered responses, a busy watchdog and a grant observation port.
module pmem_rr_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH-1:0]            ch_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_address,
    input  logic [NUM_CH*LINE_WIDTH-1:0] ch_wdata,
    output logic [LINE_WIDTH-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]            ch_resp,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [ADDR_WIDTH-1:0]        pmem_address,
    output logic [LINE_WIDTH-1:0]        pmem_wdata,
    input  logic [LINE_WIDTH-1:0]        pmem_rdata,
    input  logic                         pmem_resp,
    output logic                         grant_valid,
    output logic [$clog2(NUM_CH)-1:0]    grant_idx,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [IDX_W-1:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic [IDX_W-1:0]        grant_idx_r, grant_idx_nxt_s;
    logic                    grant_valid_r, grant_valid_nxt_s;
    logic                    pmem_read_r, pmem_read_nxt_s;
    logic                    pmem_write_r, pmem_write_nxt_s;
    logic [ADDR_WIDTH-1:0]   pmem_address_r, pmem_address_nxt_s;
    logic [LINE_WIDTH-1:0]   pmem_wdata_r, pmem_wdata_nxt_s;
    logic [LINE_WIDTH-1:0]   ch_rdata_r, ch_rdata_nxt_s;
    logic [NUM_CH-1:0]       ch_resp_r, ch_resp_nxt_s;
    logic [WD_W-1:0]         wd_cnt_r, wd_cnt_nxt_s;
    logic                    timeout_err_r, timeout_err_nxt_s;

    logic [NUM_CH-1:0]       req_s;
    logic [IDX_W-1:0]        winner_s;
    logic                    any_req_s;
    logic                    win_write_s;
    logic [IDX_W:0]          cand_sum_s;
    logic [IDX_W:0]          cand_s;
    logic                    cand_hit_s;
    logic [ADDR_WIDTH-1:0]   addr_arr_s  [NUM_CH];
    logic [LINE_WIDTH-1:0]   wdata_arr_s [NUM_CH];

    assign req_s = ch_read | ch_write;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_arr_s[g]  = ch_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr_s[g] = ch_wdata[g*LINE_WIDTH +: LINE_WIDTH];
    end

    // Round-robin search: scan from the far end so the nearest requester after rr_ptr wins last.
    always_comb begin
        winner_s   = '0;
        any_req_s  = 1'b0;
        cand_sum_s = '0;
        cand_s     = '0;
        cand_hit_s = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand_sum_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
            cand_s     = (cand_sum_s >= NUM_CH_W) ? (cand_sum_s - NUM_CH_W) : cand_sum_s;
            cand_hit_s = req_s[cand_s[IDX_W-1:0]];
            winner_s   = cand_hit_s ? cand_s[IDX_W-1:0] : winner_s;
            any_req_s  = any_req_s | cand_hit_s;
        end
    end

    // Simultaneous read and write on one channel is resolved as a write.
    assign win_write_s = ch_write[winner_s];

    // Next-state and next-output logic of the IDLE/BUSY/DONE controller.
    always_comb begin
        state_nxt_s        = state_r;
        rr_ptr_nxt_s       = rr_ptr_r;
        grant_idx_nxt_s    = grant_idx_r;
        pmem_read_nxt_s    = pmem_read_r;
        pmem_write_nxt_s   = pmem_write_r;
        pmem_address_nxt_s = pmem_address_r;
        pmem_wdata_nxt_s   = pmem_wdata_r;
        ch_rdata_nxt_s     = ch_rdata_r;
        ch_resp_nxt_s      = '0;
        wd_cnt_nxt_s       = wd_cnt_r;
        timeout_err_nxt_s  = timeout_err_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s        = ST_BUSY;
                    grant_idx_nxt_s    = winner_s;
                    rr_ptr_nxt_s       = winner_s;
                    pmem_address_nxt_s = addr_arr_s[winner_s];
                    pmem_write_nxt_s   = win_write_s;
                    pmem_read_nxt_s    = ~win_write_s;
                    wd_cnt_nxt_s       = '0;
                    if (win_write_s) begin
                        pmem_wdata_nxt_s = wdata_arr_s[winner_s];
                    end else begin
                        pmem_wdata_nxt_s = pmem_wdata_r;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (pmem_resp) begin
                    state_nxt_s      = ST_DONE;
                    pmem_read_nxt_s  = 1'b0;
                    pmem_write_nxt_s = 1'b0;
                    ch_resp_nxt_s    = NUM_CH'(1) << grant_idx_r;
                    if (pmem_read_r) begin
                        ch_rdata_nxt_s = pmem_rdata;
                    end else begin
                        ch_rdata_nxt_s = ch_rdata_r;
                    end
                end else begin
                    // Saturating count of unanswered busy cycles; the flag is sticky until reset.
                    if (WD_EN && (wd_cnt_r != WD_MAX)) begin
                        wd_cnt_nxt_s = wd_cnt_r + WD_W'(1);
                    end else begin
                        wd_cnt_nxt_s = wd_cnt_r;
                    end
                    if (WD_EN && (wd_cnt_r == (WD_MAX - WD_W'(1)))) begin
                        timeout_err_nxt_s = 1'b1;
                    end else begin
                        timeout_err_nxt_s = timeout_err_r;
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                pmem_read_nxt_s  = 1'b0;
                pmem_write_nxt_s = 1'b0;
            end
        endcase
        grant_valid_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            rr_ptr_r       <= IDX_W'(NUM_CH - 1);
            grant_idx_r    <= '0;
            grant_valid_r  <= 1'b0;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= '0;
            pmem_wdata_r   <= '0;
            ch_rdata_r     <= '0;
            ch_resp_r      <= '0;
            wd_cnt_r       <= '0;
            timeout_err_r  <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            rr_ptr_r       <= rr_ptr_nxt_s;
            grant_idx_r    <= grant_idx_nxt_s;
            grant_valid_r  <= grant_valid_nxt_s;
            pmem_read_r    <= pmem_read_nxt_s;
            pmem_write_r   <= pmem_write_nxt_s;
            pmem_address_r <= pmem_address_nxt_s;
            pmem_wdata_r   <= pmem_wdata_nxt_s;
            ch_rdata_r     <= ch_rdata_nxt_s;
            ch_resp_r      <= ch_resp_nxt_s;
            wd_cnt_r       <= wd_cnt_nxt_s;
            timeout_err_r  <= timeout_err_nxt_s;
        end
    end

    assign ch_rdata     = ch_rdata_r;
    assign ch_resp      = ch_resp_r;
    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = pmem_address_r;
    assign pmem_wdata   = pmem_wdata_r;
    assign grant_valid  = grant_valid_r;
    assign grant_idx    = grant_idx_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// Self-checking bench for pmem_rr_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level round-robin model.
module tb_pmem_rr_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_read;
    logic [NCH-1:0]    ch_write;
    logic [NCH*AW-1:0] ch_address;
    logic [NCH*LW-1:0] ch_wdata;
    logic [LW-1:0]     ch_rdata;
    logic [NCH-1:0]    ch_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [AW-1:0]     pmem_address;
    logic [LW-1:0]     pmem_wdata;
    logic [LW-1:0]     pmem_rdata;
    logic              pmem_resp;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] tb_addr  [NCH];
    logic [LW-1:0] tb_wdata [NCH];
    logic [LW-1:0] exp_rdata;
    bit            exp_err;
    int            last_g;

    typedef struct {
        logic [NCH-1:0] rd;
        logic [NCH-1:0] wr;
        int             lat;
        int             exp_g;
    } vec_t;

    pmem_rr_arbiter #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_read(ch_read), .ch_write(ch_write), .ch_address(ch_address), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata), .ch_resp(ch_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Round-robin rule: first requester after the previous winner, wrapping around.
    function automatic int pick(input logic [NCH-1:0] p, input int last);
        for (int k = 1; k <= NCH; k++) begin
            if (p[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr);
        ch_read  = rd;
        ch_write = wr;
        for (int c = 0; c < NCH; c++) begin
            ch_address[c*AW +: AW] = tb_addr[c];
            ch_wdata[c*LW +: LW]   = tb_wdata[c];
        end
    endtask

    // One complete transaction, entered in an IDLE cycle; checks every cycle through DONE.
    task automatic do_txn(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr, input int lat,
                          input int g, input logic [LW-1:0] rdata);
        logic          is_wr;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        is_wr = wr[g];
        a     = tb_addr[g];
        wd    = tb_wdata[g];
        drive_reqs(rd, wr);
        chk("idle_grant_valid", LW'(grant_valid), LW'(0));
        chk("idle_resp", LW'(ch_resp), LW'(0));
        tick();
        ch_address = ~ch_address;
        ch_wdata   = ~ch_wdata;
        ch_read    = NCH'($urandom);
        ch_write   = NCH'($urandom);
        for (int c = 1; c <= lat; c++) begin
            if (c >= TO + 1) exp_err = 1'b1;
            pmem_resp  = (c == lat);
            pmem_rdata = (c == lat) ? rdata : rand_line();
            chk("busy_read", LW'(pmem_read), LW'(!is_wr));
            chk("busy_write", LW'(pmem_write), LW'(is_wr));
            chk("busy_addr", LW'(pmem_address), LW'(a));
            if (is_wr) chk("busy_wdata", pmem_wdata, wd);
            chk("busy_grant_idx", LW'(grant_idx), LW'(g));
            chk("busy_grant_valid", LW'(grant_valid), LW'(1));
            chk("busy_resp", LW'(ch_resp), LW'(0));
            chk("busy_timeout", LW'(timeout_err), LW'(exp_err));
            tick();
        end
        pmem_resp  = 1'($urandom);
        pmem_rdata = rand_line();
        ch_read    = '0;
        ch_write   = '0;
        if (!is_wr) exp_rdata = rdata;
        chk("done_resp", LW'(ch_resp), LW'(NCH'(1) << g));
        chk("done_pmem_rw", LW'({pmem_read, pmem_write}), LW'(0));
        chk("done_rdata", ch_rdata, exp_rdata);
        chk("done_grant_valid", LW'(grant_valid), LW'(1));
        chk("done_timeout", LW'(timeout_err), LW'(exp_err));
        tick();
        chk("post_grant_valid", LW'(grant_valid), LW'(0));
        chk("post_resp", LW'(ch_resp), LW'(0));
        pmem_resp = 1'($urandom);
        last_g    = g;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        ch_read   = '0;
        ch_write  = '0;
        pmem_resp = 1'b0;
        #1;
        chk("rst_pmem_rw", LW'({pmem_read, pmem_write}), LW'(0));
        chk("rst_addr", LW'(pmem_address), LW'(0));
        chk("rst_wdata", pmem_wdata, LW'(0));
        chk("rst_rdata", ch_rdata, LW'(0));
        chk("rst_resp", LW'(ch_resp), LW'(0));
        chk("rst_grant", LW'({grant_valid, grant_idx}), LW'(0));
        chk("rst_timeout", LW'(timeout_err), LW'(0));
        tick();
        chk("rst_hold_resp", LW'(ch_resp), LW'(0));
        tick();
        rst       = 1'b1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        last_g    = NCH - 1;
    endtask

    initial begin
        vec_t           tbl [10];
        logic [NCH-1:0] pend_rd;
        logic [NCH-1:0] pend_wr;
        int             g;
        int             op;

        tbl[0] = '{4'b0011, 4'b0000, 1, 0};
        tbl[1] = '{4'b0011, 4'b0000, 2, 1};
        tbl[2] = '{4'b0011, 4'b0000, 1, 0};
        tbl[3] = '{4'b1000, 4'b0100, 3, 2};
        tbl[4] = '{4'b0000, 4'b0101, 1, 0};
        tbl[5] = '{4'b0010, 4'b0010, 2, 1};
        tbl[6] = '{4'b1111, 4'b0000, 1, 2};
        tbl[7] = '{4'b1011, 4'b0000, 3, 3};
        tbl[8] = '{4'b0110, 4'b0000, 1, 1};
        tbl[9] = '{4'b1000, 4'b0000, 2, 3};

        ch_read    = '0;
        ch_write   = '0;
        ch_address = '0;
        ch_wdata   = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            tb_addr[c]  = '0;
            tb_wdata[c] = '0;
        end
        #2;
        do_reset();

        // Single read, then a write that must leave ch_rdata alone.
        tb_addr[0] = 32'h0000_0060;
        do_txn(4'b0001, 4'b0000, 4, 0, {8{32'hDEAD_BEEF}});
        tb_addr[1]  = 32'h0000_1000;
        tb_wdata[1] = {32{8'hA5}};
        do_txn(4'b0000, 4'b0010, 2, 1, rand_line());

        // Directed arbitration table from a fresh reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < NCH; c++) begin
                tb_addr[c]  = 32'h1000_0000 + 32'(c * 64) + 32'(i);
                tb_wdata[c] = rand_line();
            end
            do_txn(tbl[i].rd, tbl[i].wr, tbl[i].lat, tbl[i].exp_g, rand_line());
        end

        // Persistent contention from all channels.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_txn(4'b1111, 4'b0000, 1 + (i % 3), i % NCH, rand_line());
        end

        // Randomized traffic checked against the round-robin model.
        do_reset();
        pend_rd = '0;
        pend_wr = '0;
        for (int t = 0; t < 60; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!(pend_rd[c] | pend_wr[c]) && ($urandom_range(0, 1) == 1)) begin
                    op          = $urandom_range(0, 7);
                    pend_wr[c]  = (op >= 4);
                    pend_rd[c]  = (op < 4) || (op == 7);
                    tb_addr[c]  = $urandom;
                    tb_wdata[c] = rand_line();
                end
            end
            if (((pend_rd | pend_wr) == '0) || ($urandom_range(0, 4) == 0)) begin
                ch_read  = '0;
                ch_write = '0;
                tick();
                chk("idle_no_grant", LW'(grant_valid), LW'(0));
                chk("idle_no_pmem", LW'({pmem_read, pmem_write}), LW'(0));
            end
            if ((pend_rd | pend_wr) == '0) begin
                g          = $urandom_range(0, NCH - 1);
                pend_rd[g] = 1'b1;
                tb_addr[g] = $urandom;
            end
            g = pick(pend_rd | pend_wr, last_g);
            do_txn(pend_rd, pend_wr, $urandom_range(1, 6), g, rand_line());
            pend_rd[g] = 1'b0;
            pend_wr[g] = 1'b0;
        end

        // Watchdog: withheld response, late completion, sticky flag.
        tb_addr[2] = 32'h0000_2200;
        g = pick(4'b0100, last_g);
        do_txn(4'b0100, 4'b0000, 20, g, rand_line());
        tb_addr[0]  = 32'h0000_3300;
        tb_wdata[0] = rand_line();
        g = pick(4'b0001, last_g);
        do_txn(4'b0000, 4'b0001, 2, g, rand_line());

        // Reset during BUSY abandons the read; channel 1 alone is granted afterwards.
        tb_addr[0] = 32'h0000_4400;
        drive_reqs(4'b0001, 4'b0000);
        pmem_resp = 1'b0;
        tick();
        chk("mid_busy_read", LW'(pmem_read), LW'(1));
        tick();
        tick();
        #2;
        do_reset();
        tb_addr[1] = 32'h0000_5500;
        do_txn(4'b0010, 4'b0000, 2, 1, rand_line());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_rr_arbiter.md
Name: pmem_rr_arbiter

Overview:
- Parametrised physical-memory arbiter. It multiplexes NUM_CH cache-line clients (I-cache, D-cache, and future prefetch or victim buffers) onto the single pmem port of mp4.
- Successor to the fixed two-cache hookup. Adds round-robin fairness, registered responses, a busy-timeout watchdog and a grant/occupancy observation port for shadow-memory checking.

Parameters:
NUM_CH, 2, number of client channels (≥2)
ADDR_WIDTH, 32, address width
LINE_WIDTH, 256, cache-line data width
TIMEOUT_CYCLES, 1024, BUSY cycles without pmem_resp before timeout_err is set; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
ch_read  in  NUM_CH  per-channel line read request
ch_write  in  NUM_CH  per-channel line write request
ch_address  in  NUM_CH*ADDR_WIDTH  per-channel address, channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_wdata  in  NUM_CH*LINE_WIDTH  per-channel write line, same packing
ch_rdata  out  LINE_WIDTH  registered read line, shared by all channels
ch_resp  out  NUM_CH  one-hot, one-cycle completion pulse
pmem_read  out  1  memory read
pmem_write  out  1  memory write
pmem_address  out  ADDR_WIDTH  latched address
pmem_wdata  out  LINE_WIDTH  latched write line
pmem_rdata  in  LINE_WIDTH  memory read line
pmem_resp  in  1  memory completion
grant_valid  out  1  high in BUSY and DONE
grant_idx  out  $clog2(NUM_CH)  channel currently owning pmem
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0; ch_rdata=0.
  - rr_ptr=NUM_CH-1, so channel 0 has first priority.
  - Watchdog counter=0; timeout_err=0.
  - Reset asserted mid-transaction abandons it with no ch_resp.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req[i] = ch_read[i] | ch_write[i].
  - Winner = first requesting i scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - If any request is present: latch grant_idx=winner, pmem_address=ch_address[winner] and op. If the op is a write, also latch pmem_wdata=ch_wdata[winner].
  - Then rr_ptr←winner and go to BUSY.
  - With no requests, stay in IDLE.
- Read and write both high on one channel: illegal. The arbiter performs the write.
- BUSY:
  - pmem_read or pmem_write held high constantly. Address and wdata stay stable.
  - Client inputs are ignored.
  - On pmem_resp=1: capture ch_rdata←pmem_rdata (reads only; writes leave ch_rdata unchanged), drop pmem_read/pmem_write, go to DONE.
- DONE:
  - ch_resp[grant_idx]=1 for exactly this one cycle.
  - Next state IDLE.
  - Clients must deassert their request in the cycle after ch_resp is seen. The IDLE sampling cycle after DONE provides this margin.
- Latency:
  - Request sampled in IDLE at cycle 0; pmem_read/pmem_write high from cycle 1.
  - pmem_resp at cycle k gives ch_resp at cycle k+1.
  - Minimum 3 cycles per transaction (pmem_resp at cycle 1 → ch_resp at cycle 2, IDLE again at cycle 3).
- Back-to-back: an arbitration cycle in IDLE always occurs between DONE and the next BUSY. This prevents re-granting a stale request.
- Fairness: a persistently requesting channel waits at most NUM_CH-1 transactions.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES (if nonzero), timeout_err←1.
  - The arbiter keeps waiting. Only reset clears timeout_err.
  - The counter saturates and does not wrap.
- pmem_resp outside BUSY is ignored.

Test Plan:
- Single read: ch_read[0]=1, addr 0x0000_0060, pmem_resp after 4 cycles, rdata=0xDEAD…BEEF → pmem_read high cycles 1–4, ch_rdata=0xDEAD…BEEF, ch_resp=2'b01 for one cycle at cycle 5.
- Simultaneous requests after reset: ch_read=2'b11 → ch0 served first, then ch1. ch_resp pulses 01 then 10; grant_idx 0 then 1.
- Persistent contention, NUM_CH=4, all channels request continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Write: ch_write[1]=1, addr 0x1000, wdata=0xA5…A5 → pmem_write=1, pmem_address=0x1000, pmem_wdata=0xA5…A5, ch_rdata unchanged, ch_resp=2'b10 after pmem_resp.
- Watchdog: TIMEOUT_CYCLES=16, pmem_resp withheld → timeout_err=1 after 16 BUSY cycles, pmem_read still high. A late pmem_resp still completes the transaction with ch_resp; timeout_err stays 1.
- Reset mid-BUSY: rst=0 asserted during cycle 3 of a read → all outputs 0 immediately, no ch_resp. After release, ch_read[1] alone is granted first.
